// File: rtl/stall_scoreboard_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: the shadow
// scoreboard entry layout, the stage indices into the scoreboard and the
// destination-match helper.
package pcpu;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
   } sb_entry_t;

   localparam int SB_EX    = 0;
   localparam int SB_MEM   = 1;
   localparam int SB_WB    = 2;
   localparam int SB_DEPTH = 3;

   localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: 5'd0};

   // x0 is never a real dependency, so it never matches.
   function automatic logic sb_match(input sb_entry_t e, input logic [4:0] a);
      return e.valid && (e.rd == a) && (a != 5'd0);
   endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping, so the
// debug display never shows a misleadingly small count after overflow.
module sat_counter32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] cnt
);

   logic [31:0] cnt_q;

   // Count up on inc; no assignment at all once saturated.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 32'd0;
      end else if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/stall_scoreboard.sv
// Hazard and stall controller for the five-stage stalling pipeline.
// A shadow scoreboard tracks the destinations in flight in EX/MEM/WB; the
// ID-stage sources are matched against it to decide stalls, and a branch or
// jump resolved in MEM squashes the younger stages. There is no valid/ready
// handshake here: every control output is a pure per-cycle level, valid in
// the same cycle as the ID inputs, and the pipeline registers obey it
// unconditionally. sb_dbg exposes the scoreboard contents for observation.
module stall_scoreboard
   import pcpu::*;
#(
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [4:0]                 Rs1_addr_ID,
   input  logic [4:0]                 Rs2_addr_ID,
   input  logic                       Rs1_used,
   input  logic                       Rs2_used,
   input  logic [4:0]                 Rd_addr_ID,
   input  logic                       RegWrite_ID,
   input  logic                       valid_ID,
   input  logic                       redirect_MEM,
   output logic                       stall_PC,
   output logic                       stall_IFID,
   output logic                       bubble_IDEX,
   output logic                       flush_IFID,
   output logic                       flush_IDEX,
   output logic                       flush_EXMEM,
   output logic [31:0]                stall_cnt,
   output logic [31:0]                flush_cnt,
   output sb_entry_t [SB_DEPTH-1:0]   sb_dbg
);

   sb_entry_t [SB_DEPTH-1:0] sb;
   logic                     rs1_hit;
   logic                     rs2_hit;
   logic                     hazard;

   // RAW detection: a source is blocked while its producer sits in EX or MEM,
   // and also in WB when the register file cannot write-before-read.
   always_comb begin
      rs1_hit = sb_match(sb[SB_EX], Rs1_addr_ID) || sb_match(sb[SB_MEM], Rs1_addr_ID)
                || (!WB_BYPASS && sb_match(sb[SB_WB], Rs1_addr_ID));
      rs2_hit = sb_match(sb[SB_EX], Rs2_addr_ID) || sb_match(sb[SB_MEM], Rs2_addr_ID)
                || (!WB_BYPASS && sb_match(sb[SB_WB], Rs2_addr_ID));
      hazard  = valid_ID && ((Rs1_used && rs1_hit) || (Rs2_used && rs2_hit));
   end

   // Control decode: a redirect squashes everything younger and overrides any stall.
   always_comb begin
      stall_PC    = 1'b0;
      stall_IFID  = 1'b0;
      bubble_IDEX = 1'b0;
      flush_IFID  = 1'b0;
      flush_IDEX  = 1'b0;
      flush_EXMEM = 1'b0;
      if (redirect_MEM) begin
         flush_IFID  = 1'b1;
         flush_IDEX  = 1'b1;
         flush_EXMEM = 1'b1;
      end else if (hazard) begin
         stall_PC    = 1'b1;
         stall_IFID  = 1'b1;
         bubble_IDEX = 1'b1;
      end
   end

   // Scoreboard shift. The redirecting instruction (in MEM) keeps its entry so
   // a JAL/JALR link register stays tracked; only the squashed EX slot and a
   // stalled or non-writing ID instruction enter as empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb[SB_EX]  <= SB_EMPTY;
         sb[SB_MEM] <= SB_EMPTY;
         sb[SB_WB]  <= SB_EMPTY;
      end else begin
         sb[SB_WB]  <= sb[SB_MEM];
         sb[SB_MEM] <= redirect_MEM ? SB_EMPTY : sb[SB_EX];
         if (redirect_MEM || hazard || !valid_ID || !RegWrite_ID || (Rd_addr_ID == 5'd0)) begin
            sb[SB_EX] <= SB_EMPTY;
         end else begin
            sb[SB_EX] <= '{valid: 1'b1, rd: Rd_addr_ID};
         end
      end
   end

   assign sb_dbg = sb;

   sat_counter32 u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_PC),
      .cnt (stall_cnt)
   );

   sat_counter32 u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (redirect_MEM),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_stall_scoreboard.sv
// Bench for stall_scoreboard: one instance with the WB bypass and one
// without, driven by directed per-cycle ID vectors. Each issued vector
// pushes its hand-computed expected controls (plus optional counter and
// scoreboard expectations) into exp_q; the monitor pops and compares.
module tb_stall_scoreboard;

   typedef struct packed {
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       v;
      logic       redir;
   } id_vec_t;

   typedef struct packed {
      logic [15:0] tid;
      logic        sel;
      logic [5:0]  ctrl;
      logic        chk_s;
      logic [31:0] exp_s;
      logic        chk_f;
      logic [31:0] exp_f;
      logic        chk_sb;
      logic [17:0] exp_sb;
   } exp_t;

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] STL  = 6'b111000;
   localparam logic [5:0] FLU  = 6'b000111;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_vec_t     vec_b = '0;
   id_vec_t     vec_n = '0;
   logic [5:0]  ctrl_b, ctrl_n;
   logic [31:0] scnt_b, fcnt_b, scnt_n, fcnt_n;
   logic [17:0] sb_b, sb_n;
   logic        sp_b, si_b, bb_b, fi_b, fe_b, fm_b;
   logic        sp_n, si_n, bb_n, fi_n, fe_n, fm_n;

   assign ctrl_b = {sp_b, si_b, bb_b, fi_b, fe_b, fm_b};
   assign ctrl_n = {sp_n, si_n, bb_n, fi_n, fe_n, fm_n};

   stall_scoreboard #(.WB_BYPASS(1'b1)) dut_b (
      .clk(clk), .rst(rst),
      .Rs1_addr_ID(vec_b.rs1), .Rs2_addr_ID(vec_b.rs2),
      .Rs1_used(vec_b.u1), .Rs2_used(vec_b.u2),
      .Rd_addr_ID(vec_b.rd), .RegWrite_ID(vec_b.rw),
      .valid_ID(vec_b.v), .redirect_MEM(vec_b.redir),
      .stall_PC(sp_b), .stall_IFID(si_b), .bubble_IDEX(bb_b),
      .flush_IFID(fi_b), .flush_IDEX(fe_b), .flush_EXMEM(fm_b),
      .stall_cnt(scnt_b), .flush_cnt(fcnt_b), .sb_dbg(sb_b)
   );

   stall_scoreboard #(.WB_BYPASS(1'b0)) dut_n (
      .clk(clk), .rst(rst),
      .Rs1_addr_ID(vec_n.rs1), .Rs2_addr_ID(vec_n.rs2),
      .Rs1_used(vec_n.u1), .Rs2_used(vec_n.u2),
      .Rd_addr_ID(vec_n.rd), .RegWrite_ID(vec_n.rw),
      .valid_ID(vec_n.v), .redirect_MEM(vec_n.redir),
      .stall_PC(sp_n), .stall_IFID(si_n), .bubble_IDEX(bb_n),
      .flush_IFID(fi_n), .flush_IDEX(fe_n), .flush_EXMEM(fm_n),
      .stall_cnt(scnt_n), .flush_cnt(fcnt_n), .sb_dbg(sb_n)
   );

   // scoreboard state
   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          step_no = 0;
   logic        pend_s_en = 1'b0, pend_f_en = 1'b0, pend_sb_en = 1'b0;
   logic [31:0] pend_s = '0, pend_f = '0;
   logic [17:0] pend_sb = '0;

   // driver helpers
   function automatic id_vec_t ins(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                   input logic [4:0] rs2, input logic u2);
      id_vec_t t;
      t = '0;
      t.rd = rd; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
      t.rw = 1'b1; t.v = 1'b1;
      return t;
   endfunction

   function automatic id_vec_t idle();
      return '0;
   endfunction

   task automatic want_stall(input logic [31:0] s);
      pend_s_en = 1'b1; pend_s = s;
   endtask

   task automatic want_flush(input logic [31:0] f);
      pend_f_en = 1'b1; pend_f = f;
   endtask

   task automatic want_sb(input logic [17:0] x);
      pend_sb_en = 1'b1; pend_sb = x;
   endtask

   // Presents one ID vector for one cycle to the selected instance (the other idles).
   task automatic step(input logic sel, input id_vec_t v, input logic [5:0] ctrl);
      exp_t e;
      if (sel) begin
         vec_n = v; vec_b = '0;
      end else begin
         vec_b = v; vec_n = '0;
      end
      e = '0;
      e.tid = 16'(step_no); e.sel = sel; e.ctrl = ctrl;
      e.chk_s = pend_s_en; e.exp_s = pend_s;
      e.chk_f = pend_f_en; e.exp_f = pend_f;
      e.chk_sb = pend_sb_en; e.exp_sb = pend_sb;
      exp_q.push_back(e);
      pend_s_en = 1'b0; pend_f_en = 1'b0; pend_sb_en = 1'b0;
      step_no++;
      @(posedge clk);
      #1;
   endtask

   // monitor
   exp_t        cur;
   logic [5:0]  act_ctrl;
   logic [31:0] act_s, act_f;
   logic [17:0] act_sb;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur      = exp_q.pop_front();
         act_ctrl = cur.sel ? ctrl_n : ctrl_b;
         act_s    = cur.sel ? scnt_n : scnt_b;
         act_f    = cur.sel ? fcnt_n : fcnt_b;
         act_sb   = cur.sel ? sb_n   : sb_b;
         n_cmp++;
         if (act_ctrl !== cur.ctrl) begin
            n_err++;
            $display("FAIL ctrl step%0d dut%0d: got %b want %b", cur.tid, cur.sel, act_ctrl, cur.ctrl);
         end
         if (cur.chk_s) begin
            n_cmp++;
            if (act_s !== cur.exp_s) begin
               n_err++;
               $display("FAIL stall_cnt step%0d dut%0d: got %h want %h", cur.tid, cur.sel, act_s, cur.exp_s);
            end
         end
         if (cur.chk_f) begin
            n_cmp++;
            if (act_f !== cur.exp_f) begin
               n_err++;
               $display("FAIL flush_cnt step%0d dut%0d: got %h want %h", cur.tid, cur.sel, act_f, cur.exp_f);
            end
         end
         if (cur.chk_sb) begin
            n_cmp++;
            if (act_sb !== cur.exp_sb) begin
               n_err++;
               $display("FAIL sb step%0d dut%0d: got %h want %h", cur.tid, cur.sel, act_sb, cur.exp_sb);
            end
         end
      end
   end

   // stimulus
   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state, both instances
      want_stall(0); want_flush(0); want_sb(18'h0); step(0, idle(), NONE);
      want_stall(0); want_flush(0); want_sb(18'h0); step(1, idle(), NONE);

      // distance 1, bypass: 2 stalls
      step(0, ins(5, 0, 0, 0, 0), NONE);
      step(0, ins(6, 5, 1, 5, 1), STL);
      step(0, ins(6, 5, 1, 5, 1), STL);
      step(0, ins(6, 5, 1, 5, 1), NONE);
      want_stall(2); step(0, idle(), NONE);

      // distance 1, no bypass: 3 stalls
      step(1, ins(5, 0, 0, 0, 0), NONE);
      step(1, ins(6, 5, 1, 5, 1), STL);
      step(1, ins(6, 5, 1, 5, 1), STL);
      step(1, ins(6, 5, 1, 5, 1), STL);
      step(1, ins(6, 5, 1, 5, 1), NONE);
      want_stall(3); step(1, idle(), NONE);

      // distance 2, no bypass: 2 stalls
      step(1, ins(10, 0, 0, 0, 0), NONE);
      step(1, idle(), NONE);
      step(1, ins(11, 10, 1, 0, 0), STL);
      step(1, ins(11, 10, 1, 0, 0), STL);
      step(1, ins(11, 10, 1, 0, 0), NONE);
      want_stall(5); step(1, idle(), NONE);

      // distance 3 via Rs2, no bypass: 1 stall
      step(1, ins(12, 0, 0, 0, 0), NONE);
      step(1, idle(), NONE);
      step(1, idle(), NONE);
      step(1, ins(13, 0, 0, 12, 1), STL);
      step(1, ins(13, 0, 0, 12, 1), NONE);
      want_stall(6); step(1, idle(), NONE);

      // distance 3, bypass: no stall
      step(0, ins(14, 0, 0, 0, 0), NONE);
      step(0, idle(), NONE);
      step(0, idle(), NONE);
      step(0, ins(15, 14, 1, 0, 0), NONE);

      // x0 never a dependency
      step(0, ins(0, 0, 0, 0, 0), NONE);
      step(0, ins(7, 0, 1, 0, 1), NONE);
      // Rs2 matches but unused: only Rs1 stalls
      step(0, ins(8, 0, 0, 0, 0), NONE);
      step(0, ins(9, 8, 1, 8, 0), STL);
      step(0, ins(9, 8, 1, 8, 0), STL);
      step(0, ins(9, 8, 1, 8, 0), NONE);
      want_stall(4); step(0, idle(), NONE);
      // both sources matching but unused, and matching with valid_ID=0
      step(0, ins(16, 0, 0, 0, 0), NONE);
      step(0, ins(17, 16, 0, 16, 0), NONE);
      step(0, ins(18, 0, 0, 0, 0), NONE);
      vec_b = ins(19, 18, 1, 18, 1);
      step(0, '{rs1: 5'd18, u1: 1'b1, rs2: 5'd18, u2: 1'b1, rd: 5'd19, rw: 1'b1, v: 1'b0, redir: 1'b0}, NONE);

      // two sources, different producers: max of the two stall counts
      step(0, ins(12, 0, 0, 0, 0), NONE);
      step(0, ins(13, 0, 0, 0, 0), NONE);
      step(0, ins(20, 12, 1, 13, 1), STL);
      step(0, ins(20, 12, 1, 13, 1), STL);
      step(0, ins(20, 12, 1, 13, 1), NONE);
      want_stall(6); step(0, idle(), NONE);

      // redirect during the first stall cycle, JAL rd=1 in MEM
      step(0, ins(1, 0, 0, 0, 0), NONE);
      step(0, ins(5, 0, 0, 0, 0), NONE);
      step(0, '{rs1: 5'd5, u1: 1'b1, rs2: 5'd5, u2: 1'b1, rd: 5'd6, rw: 1'b1, v: 1'b1, redir: 1'b1}, FLU);
      want_stall(6); want_flush(1); want_sb({6'b1_00001, 6'b0, 6'b0});
      step(0, idle(), NONE);

      // reset pulsed during a stall
      step(0, ins(5, 0, 0, 0, 0), NONE);
      rst = 1'b1;
      step(0, ins(6, 5, 1, 5, 1), STL);
      rst = 1'b0;
      want_stall(0); want_flush(0); want_sb(18'h0);
      step(0, ins(6, 5, 1, 5, 1), NONE);
      want_stall(0); want_flush(0); step(1, idle(), NONE);

      // saturation of stall_cnt
      step(0, idle(), NONE);
      step(0, idle(), NONE);
      force dut_b.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut_b.u_stall_cnt.cnt_q;
      want_stall(32'hFFFF_FFFE); step(0, ins(5, 0, 0, 0, 0), NONE);
      want_stall(32'hFFFF_FFFE); step(0, ins(6, 5, 1, 5, 1), STL);
      want_stall(32'hFFFF_FFFF); step(0, ins(6, 5, 1, 5, 1), STL);
      want_stall(32'hFFFF_FFFF); step(0, ins(6, 5, 1, 5, 1), NONE);
      step(0, ins(7, 6, 1, 0, 0), STL);
      step(0, ins(7, 6, 1, 0, 0), STL);
      want_stall(32'hFFFF_FFFF); step(0, ins(7, 6, 1, 0, 0), NONE);

      vec_b = '0;
      vec_n = '0;
      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
